// File: rtl/ramfifo_ctrl_multi_pkg.sv
// Shared constants and the RAM address helper for the multi-channel FIFO control.
package ramfifo_ctrl_multi_pkg;
  localparam int LOG_DEP_DEF = 6;
  localparam int LOG_NVC_DEF = 1;
  localparam int DEPTH       = 1 << LOG_DEP_DEF;
  localparam int NUM_VC      = 1 << LOG_NVC_DEF;
  localparam int CNT_W       = LOG_DEP_DEF + 1;

  // Build {vc, ptr}: channel number in the upper bits, pointer in the low log_dep bits.
  // Callers cast the result down to their address width.
  function automatic logic [31:0] vc_addr(input logic [31:0] vc, input logic [31:0] ptr,
                                          input int log_dep);
    return (vc << log_dep) | ptr;
  endfunction
endpackage

// File: rtl/ramfifo_ctrl_multi_if.sv
// Request/status bundle between port logic and the shared-RAM FIFO control.
interface ramfifo_ctrl_multi_if #(
  parameter int LOG_DEP = 6,
  parameter int LOG_NVC = 1
);
  localparam int NVC = 1 << LOG_NVC;
  localparam int CW  = LOG_DEP + 1;
  localparam int AW  = LOG_NVC + LOG_DEP;

  logic               enable;
  logic               write;
  logic [LOG_NVC-1:0] write_vc;
  logic               read;
  logic [LOG_NVC-1:0] read_vc;
  logic [NVC-1:0]     flush;
  logic [NVC-1:0]     full;
  logic [NVC-1:0]     empty;
  logic [NVC-1:0]     almost_full;
  logic [NVC*CW-1:0]  count;
  logic               ram_wen;
  logic [AW-1:0]      ram_waddr;
  logic [AW-1:0]      ram_raddr;
  logic [AW-1:0]      ram_raddr_next;

  modport master (
    output enable, write, write_vc, read, read_vc, flush,
    input  full, empty, almost_full, count, ram_wen, ram_waddr, ram_raddr, ram_raddr_next
  );
  modport slave (
    input  enable, write, write_vc, read, read_vc, flush,
    output full, empty, almost_full, count, ram_wen, ram_waddr, ram_raddr, ram_raddr_next
  );
endinterface

// File: rtl/ramfifo_vc_ptr.sv
// One channel's head/tail/occupancy counters and the flags decoded from them.
module ramfifo_vc_ptr #(
  parameter int LOG_DEP   = 6,
  parameter int AF_MARGIN = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc_head,
  input  logic               inc_tail,
  input  logic               flush,
  output logic [LOG_DEP-1:0] head,
  output logic [LOG_DEP-1:0] tail,
  output logic [LOG_DEP:0]   count,
  output logic               full,
  output logic               empty,
  output logic               almost_full
);
  localparam int CW = LOG_DEP + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << LOG_DEP);
  localparam logic [CW-1:0] AF_TH   = CW'((1 << LOG_DEP) - AF_MARGIN);

  // Flush beats any same-cycle read/write; simultaneous read+write leaves count alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (inc_head) head <= head + LOG_DEP'(1);
      if (inc_tail) tail <= tail + LOG_DEP'(1);
      if (inc_tail && !inc_head)      count <= count + CW'(1);
      else if (inc_head && !inc_tail) count <= count - CW'(1);
    end
  end

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_TH);
endmodule

// File: rtl/ramfifo_ctrl_multi.sv
// Accept logic and RAM address muxing over NUM_VC per-channel pointer blocks.
module ramfifo_ctrl_multi
  import ramfifo_ctrl_multi_pkg::*;
#(
  parameter int WIDTH     = 36,
  parameter int LOG_DEP   = LOG_DEP_DEF,
  parameter int LOG_NVC   = LOG_NVC_DEF,
  parameter int AF_MARGIN = 2
) (
  input logic clock,
  input logic reset,
  ramfifo_ctrl_multi_if.slave bus
);
  localparam int NVC = 1 << LOG_NVC;
  localparam int CW  = LOG_DEP + 1;
  localparam int AW  = LOG_NVC + LOG_DEP;

  // WIDTH only sizes the attached RAM; reject nonsense parameter sets at elaboration.
  if (WIDTH < 1 || AF_MARGIN < 0 || AF_MARGIN > (1 << LOG_DEP)) begin : g_bad_param
    $error("ramfifo_ctrl_multi: illegal WIDTH or AF_MARGIN");
  end

  logic [NVC-1:0][LOG_DEP-1:0] head, tail;
  logic [NVC-1:0][CW-1:0]      cnt;
  logic [NVC-1:0]              full, empty, afull, inc_head, inc_tail;
  logic                        valid_read, valid_write;
  logic [LOG_DEP-1:0]          head_nxt;

  // A full channel still takes a write when the same channel is read this cycle.
  always_comb begin
    valid_read  = bus.enable & bus.read & ~empty[bus.read_vc];
    valid_write = bus.enable & bus.write &
                  (~full[bus.write_vc] | (valid_read & (bus.read_vc == bus.write_vc)));
    inc_head = '0;
    inc_tail = '0;
    inc_head[bus.read_vc]  = valid_read;
    inc_tail[bus.write_vc] = valid_write;
  end

  for (genvar i = 0; i < NVC; i++) begin : g_vc
    ramfifo_vc_ptr #(.LOG_DEP(LOG_DEP), .AF_MARGIN(AF_MARGIN)) u_ptr (
      .clock       (clock),
      .reset       (reset),
      .inc_head    (inc_head[i]),
      .inc_tail    (inc_tail[i]),
      .flush       (bus.flush[i]),
      .head        (head[i]),
      .tail        (tail[i]),
      .count       (cnt[i]),
      .full        (full[i]),
      .empty       (empty[i]),
      .almost_full (afull[i])
    );
  end

  // RAM pins are combinational from the request and current pointers.
  always_comb begin
    head_nxt           = head[bus.read_vc] + LOG_DEP'(1);
    bus.ram_wen        = valid_write;
    bus.ram_waddr      = AW'(vc_addr(32'(bus.write_vc), 32'(tail[bus.write_vc]), LOG_DEP));
    bus.ram_raddr      = AW'(vc_addr(32'(bus.read_vc), 32'(head[bus.read_vc]), LOG_DEP));
    bus.ram_raddr_next = AW'(vc_addr(32'(bus.read_vc), 32'(head_nxt), LOG_DEP));
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = afull;
  assign bus.count       = cnt;
endmodule

// File: tb/tb_ramfifo_ctrl_multi.sv
// Directed bench with a reference model; expected RAM-pin values are queued at drive time.
module tb_ramfifo_ctrl_multi;
  localparam int LD = 6, LN = 1, NVC = 2, DEPTH = 64, CW = 7, AF = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ramfifo_ctrl_multi_if #(.LOG_DEP(LD), .LOG_NVC(LN)) bus ();
  ramfifo_ctrl_multi #(.WIDTH(36), .LOG_DEP(LD), .LOG_NVC(LN), .AF_MARGIN(AF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       wen;
    logic [6:0] wa;
    logic [6:0] ra;
    logic [6:0] rn;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  logic [5:0] m_head[NVC];
  logic [5:0] m_tail[NVC];
  int         m_cnt[NVC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NVC; i++) begin
      m_head[i] = '0;
      m_tail[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NVC; i++) begin
      chk($sformatf("%s count%0d", tag, i), 32'(bus.count[i*CW +: CW]), 32'(m_cnt[i]));
      chk($sformatf("%s full%0d", tag, i), 32'(bus.full[i]), 32'(m_cnt[i] == DEPTH));
      chk($sformatf("%s empty%0d", tag, i), 32'(bus.empty[i]), 32'(m_cnt[i] == 0));
      chk($sformatf("%s afull%0d", tag, i), 32'(bus.almost_full[i]), 32'(m_cnt[i] >= DEPTH - AF));
    end
  endtask

  task automatic step(input string tag, input logic en, input logic wr, input logic wvc,
                      input logic rd, input logic rvc, input logic [1:0] fl);
    exp_t e, o;
    logic vr, vw;
    @(negedge clock);
    bus.enable = en; bus.write = wr; bus.write_vc = wvc;
    bus.read = rd;   bus.read_vc = rvc; bus.flush = fl;
    vr = en & rd & (m_cnt[rvc] != 0);
    vw = en & wr & ((m_cnt[wvc] != DEPTH) | (vr & (rvc == wvc)));
    e.wen = vw;
    e.wa  = {wvc, m_tail[wvc]};
    e.ra  = {rvc, m_head[rvc]};
    e.rn  = {rvc, 6'(m_head[rvc] + 6'd1)};
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    chk({tag, " wen"}, 32'(bus.ram_wen), 32'(o.wen));
    chk({tag, " waddr"}, 32'(bus.ram_waddr), 32'(o.wa));
    chk({tag, " raddr"}, 32'(bus.ram_raddr), 32'(o.ra));
    chk({tag, " raddr_next"}, 32'(bus.ram_raddr_next), 32'(o.rn));
    for (int i = 0; i < NVC; i++) begin
      if (fl[i]) begin
        m_head[i] = '0; m_tail[i] = '0; m_cnt[i] = 0;
      end else begin
        if (vr && rvc == 1'(i)) begin m_head[i] = m_head[i] + 6'd1; m_cnt[i]--; end
        if (vw && wvc == 1'(i)) begin m_tail[i] = m_tail[i] + 6'd1; m_cnt[i]++; end
      end
    end
    @(posedge clock);
    #1;
    check_state(tag);
  endtask

  initial begin
    bus.enable = 0; bus.write = 0; bus.write_vc = 0;
    bus.read = 0; bus.read_vc = 0; bus.flush = '0;
    reset = 1'b1;
    model_reset();
    #12;
    chk("reset empty", 32'(bus.empty), 32'h3);
    chk("reset full", 32'(bus.full), 32'h0);
    chk("reset afull", 32'(bus.almost_full), 32'h0);
    chk("reset count", 32'(bus.count), 32'h0);
    chk("reset wen", 32'(bus.ram_wen), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Three writes then three reads on vc0.
    for (int k = 0; k < 3; k++) step("wr vc0", 1, 1, 0, 0, 0, 2'b00);
    chk("vc0 count3", 32'(bus.count[0 +: CW]), 32'd3);
    for (int k = 0; k < 3; k++) step("rd vc0", 1, 0, 0, 1, 0, 2'b00);
    chk("vc0 empty again", 32'(bus.empty[0]), 32'd1);

    // Fill vc1, over-write, then same-channel read+write while full.
    for (int k = 0; k < 64; k++) step("fill vc1", 1, 1, 1, 0, 0, 2'b00);
    chk("vc1 full", 32'(bus.full[1]), 32'd1);
    step("wr full vc1", 1, 1, 1, 0, 0, 2'b00);
    step("rw full vc1", 1, 1, 1, 1, 1, 2'b00);
    chk("vc1 count64", 32'(bus.count[CW +: CW]), 32'd64);
    for (int k = 0; k < 59; k++) step("drain vc1", 1, 0, 0, 1, 1, 2'b00);
    chk("vc1 count5", 32'(bus.count[CW +: CW]), 32'd5);

    // Wrap-around on vc0 with alternating write/read.
    for (int k = 0; k < 200; k++) begin
      step("wrap wr", 1, 1, 0, 0, 0, 2'b00);
      step("wrap rd", 1, 0, 0, 1, 0, 2'b00);
    end

    // Cross-channel write vc0 / read vc1.
    step("cross", 1, 1, 0, 1, 1, 2'b00);
    chk("cross count0", 32'(bus.count[0 +: CW]), 32'd1);
    chk("cross count1", 32'(bus.count[CW +: CW]), 32'd4);
    step("cross wr1 view", 0, 0, 1, 0, 0, 2'b00);

    // Disabled request is ignored.
    step("disabled", 0, 1, 1, 1, 1, 2'b00);

    // Bring vc1 to 10 then flush it while writing it.
    for (int k = 0; k < 6; k++) step("wr vc1", 1, 1, 1, 0, 0, 2'b00);
    chk("vc1 count10", 32'(bus.count[CW +: CW]), 32'd10);
    step("flush vc1", 1, 1, 1, 0, 0, 2'b10);
    chk("flush count1", 32'(bus.count[CW +: CW]), 32'd0);
    chk("flush count0 kept", 32'(bus.count[0 +: CW]), 32'd1);
    step("post flush", 1, 1, 1, 1, 1, 2'b00);

    // Drain vc0 and read it while empty.
    step("rd vc0 last", 1, 0, 0, 1, 0, 2'b00);
    step("rd empty vc0", 1, 0, 0, 1, 0, 2'b00);
    step("rd empty vc0 b", 1, 0, 0, 1, 0, 2'b00);

    // Asynchronous reset between clock edges clears counts immediately.
    step("pre reset wr", 1, 1, 0, 0, 0, 2'b00);
    @(negedge clock);
    bus.enable = 0; bus.write = 0; bus.read = 0; bus.flush = '0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async reset count", 32'(bus.count), 32'h0);
    chk("async reset empty", 32'(bus.empty), 32'h3);
    #1 reset = 1'b0;
    step("after reset", 1, 1, 0, 0, 0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
